// File: rtl/note_tone_pkg.sv
// note_tone_pkg: shared constants and types for the note tone generator.
// Holds the octave-3 divisor table at TABLE_HZ, the rest threshold,
// the controller state encoding and the duty-cycle encoding.
package note_tone_pkg;

  // Divisor table is expressed at this clock; the top rescales it to CLK_HZ.
  localparam int unsigned TABLE_HZ = 50_000_000;

  // Full-period divisors for C..B, octave 3, at TABLE_HZ.
  localparam int unsigned NOTE_DIV [0:11] = '{
    382225, 360774, 340525, 321413, 303372, 286346,
    270275, 255105, 240787, 227273, 214517, 202477
  };

  // note_sel values at or above this play silence.
  localparam logic [3:0] NOTE_REST = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TONE = 2'd1,
    ST_GAP  = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

  // High-phase threshold selection relative to the period divisor.
  typedef enum logic [1:0] {
    DUTY_50 = 2'd0,  // div>>1
    DUTY_25 = 2'd1,  // div>>2
    DUTY_12 = 2'd2,  // div>>3
    DUTY_75 = 2'd3   // div - div>>2
  } duty_e;

endpackage

// File: rtl/tone_divider.sv
// tone_divider: period counter plus threshold compare producing the square wave.
// Ports: clock_in/reset (sync, active-high); run, div, thresh in; clock_out out.
// Output is registered one cycle behind the counter and gated low as soon as run drops.
module tone_divider
  import note_tone_pkg::*;
#(
  parameter int CNT_W = 28
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             run,
  input  logic [CNT_W-1:0] div,
  input  logic [CNT_W-1:0] thresh,
  output logic             clock_out
);

  logic [CNT_W-1:0] cnt;
  logic             hi_q;

  always_ff @(posedge clock_in) begin
    if (reset) begin
      cnt  <= '0;
      hi_q <= 1'b0;
    end else if (run) begin
      cnt  <= (cnt == div - CNT_W'(1)) ? '0 : cnt + CNT_W'(1);
      hi_q <= (cnt < thresh);
    end else begin
      // Idle counter sits at 0 so every note starts with a fresh high phase.
      cnt  <= '0;
      hi_q <= 1'b0;
    end
  end

  // Gating with run truncates the final period the moment the tone ends.
  assign clock_out = hi_q & run;

endmodule

// File: rtl/note_tone_gen.sv
// note_tone_gen: timed square-wave note (12 semitones x 4 octaves) followed by a silent gap.
// Ports: clock_in/reset (sync, active-high); start, note_sel, octave, dur_ms in;
//        busy, done, clock_out out. Defining NOTE_DUTY_CTRL_EN adds the duty_sel input.
module note_tone_gen
  import note_tone_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int          CNT_W  = 28,
  parameter int          DUR_W  = 16,
  parameter int unsigned GAP_MS = 20
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       note_sel,
  input  logic [1:0]       octave,
  input  logic [DUR_W-1:0] dur_ms,
`ifdef NOTE_DUTY_CTRL_EN
  input  logic [1:0]       duty_sel,
`endif
  output logic             busy,
  output logic             done,
  output logic             clock_out
);

  localparam int unsigned      MS_CYC   = CLK_HZ / 1000;
  localparam int               PRE_W    = (MS_CYC > 1) ? $clog2(MS_CYC) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(MS_CYC - 1);
  localparam logic [DUR_W:0]   GAP_TGT  = (DUR_W+1)'(GAP_MS);

  // Divisor table rescaled from TABLE_HZ to CLK_HZ at elaboration (constants only).
  logic [CNT_W-1:0] div_tab [0:11];
  for (genvar g = 0; g < 12; g++) begin : g_div_tab
    localparam longint unsigned SCALED =
      (64'(NOTE_DIV[g]) * 64'(CLK_HZ)) / 64'(TABLE_HZ);
    assign div_tab[g] = CNT_W'(SCALED);
  end

  state_e           state, state_nxt;
  logic [PRE_W-1:0] pre;
  logic [DUR_W-1:0] ms_cnt, dur_r;
  logic [DUR_W:0]   ms_next;
  logic [CNT_W-1:0] div_r, div_lookup, thresh;
  logic             rest_r, tick, tone_end, gap_end, run;
`ifdef NOTE_DUTY_CTRL_EN
  duty_e            duty_r;
`endif

  assign tick     = (pre == PRE_LAST);
  assign ms_next  = {1'b0, ms_cnt} + (DUR_W+1)'(1);
  // Ending on the tick that completes the last ms makes the tone exactly dur_ms*MS_CYC cycles.
  assign tone_end = (dur_r == '0) || (tick && (ms_next == {1'b0, dur_r}));
  assign gap_end  = tick && (ms_next == GAP_TGT);

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (start)    state_nxt = ST_TONE;
      ST_TONE: if (tone_end) state_nxt = (GAP_MS == 0) ? ST_FIN : ST_GAP;
      ST_GAP:  if (gap_end)  state_nxt = ST_FIN;
      ST_FIN:                state_nxt = ST_IDLE;
      default:               state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    div_lookup = '0;
    if (note_sel < NOTE_REST) div_lookup = div_tab[note_sel] >> octave;
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state  <= ST_IDLE;
      pre    <= '0;
      ms_cnt <= '0;
      dur_r  <= '0;
      div_r  <= '0;
      rest_r <= 1'b0;
`ifdef NOTE_DUTY_CTRL_EN
      duty_r <= DUTY_50;
`endif
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && start) begin
        dur_r  <= dur_ms;
        div_r  <= div_lookup;
        rest_r <= (note_sel >= NOTE_REST);
`ifdef NOTE_DUTY_CTRL_EN
        duty_r <= duty_e'(duty_sel);
`endif
      end
      // Every state change restarts the ms timebase, so TONE and GAP both start from 0.
      if (state_nxt != state || !(state == ST_TONE || state == ST_GAP)) begin
        pre    <= '0;
        ms_cnt <= '0;
      end else if (tick) begin
        pre    <= '0;
        ms_cnt <= ms_cnt + DUR_W'(1);
      end else begin
        pre <= pre + PRE_W'(1);
      end
    end
  end

  always_comb begin
    thresh = div_r >> 1;
`ifdef NOTE_DUTY_CTRL_EN
    unique case (duty_r)
      DUTY_25: thresh = div_r >> 2;
      DUTY_12: thresh = div_r >> 3;
      DUTY_75: thresh = div_r - (div_r >> 2);
      default: thresh = div_r >> 1;
    endcase
`endif
  end

  assign run  = (state == ST_TONE) && !rest_r;
  assign busy = (state == ST_TONE) || (state == ST_GAP);
  assign done = (state == ST_FIN);

  tone_divider #(.CNT_W(CNT_W)) u_tone_divider (
    .clock_in  (clock_in),
    .reset     (reset),
    .run       (run),
    .div       (div_r),
    .thresh    (thresh),
    .clock_out (clock_out)
  );

endmodule

// File: tb/tb_note_tone_gen.sv
// tb_note_tone_gen: vector table, directed corner sequences and random notes
// checked cycle by cycle against a timeline model of the note_tone_gen behaviour.
module tb_note_tone_gen;

  localparam int unsigned CLK_HZ  = 100_000;
  localparam int unsigned GAP_MS  = 2;
  localparam int          MS      = 100;          // cycles per ms at CLK_HZ
  localparam int          GAP_CYC = 2 * MS;
  localparam int          BUDGET  = 3000;
  localparam int unsigned NOTE50 [12] = '{
    382225, 360774, 340525, 321413, 303372, 286346,
    270275, 255105, 240787, 227273, 214517, 202477
  };

  logic        clock_in = 1'b0;
  logic        reset    = 1'b1;
  logic        start    = 1'b0;
  logic [3:0]  note_sel = '0;
  logic [1:0]  octave   = '0;
  logic [15:0] dur_ms   = '0;
`ifdef NOTE_DUTY_CTRL_EN
  logic [1:0]  duty_sel = '0;
`endif
  logic        busy, done, clock_out;

  int tests = 0;
  int fails = 0;
  int model_fails = 0;
  int cur_duty = 0;
  bit mon_en = 1'b0;

  note_tone_gen #(.CLK_HZ(CLK_HZ), .CNT_W(28), .DUR_W(16), .GAP_MS(GAP_MS)) dut (
    .clock_in  (clock_in),
    .reset     (reset),
    .start     (start),
    .note_sel  (note_sel),
    .octave    (octave),
    .dur_ms    (dur_ms),
`ifdef NOTE_DUTY_CTRL_EN
    .duty_sel  (duty_sel),
`endif
    .busy      (busy),
    .done      (done),
    .clock_out (clock_out)
  );

  always #5 clock_in = ~clock_in;

  // ---------------- reference model: a timeline per accepted note ----------------
  function automatic int ref_div(input int n, input int o);
    longint unsigned s;
    if (n >= 12) return 0;
    s = (longint'(NOTE50[n]) * longint'(CLK_HZ)) / 64'd50_000_000;
    return int'(s) >> o;
  endfunction

  function automatic int ref_thr(input int d, input int dy);
    case (dy)
      1:       return d >> 2;
      2:       return d >> 3;
      3:       return d - (d >> 2);
      default: return d >> 1;
    endcase
  endfunction

  // mk = index of the current cycle since the accepting edge (1 = first busy cycle), -1 = idle.
  int mk = -1;
  int m_div = 0, m_thr = 0, m_ttone = 0, m_total = 0;
  bit m_rest = 1'b0;

  always @(posedge clock_in) begin
    if (reset) mk = -1;
    else if (mk == -1) begin
      if (start) begin
        m_rest  = (note_sel >= 4'd12);
        m_div   = ref_div(int'(note_sel), int'(octave));
        m_thr   = ref_thr(m_div, cur_duty);
        m_ttone = (dur_ms == 0) ? 1 : int'(dur_ms) * MS;
        m_total = m_ttone + GAP_CYC;
        mk      = 1;
      end
    end else if (mk >= m_total + 1) mk = -1;
    else mk = mk + 1;
  end

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  // Advance to the next falling edge and compare all outputs with the timeline model.
  task automatic tick();
    bit eb, ed, ec;
    @(negedge clock_in);
    if (mon_en && model_fails < 40) begin
      eb = (mk >= 1) && (mk <= m_total);
      ed = (mk >= 1) && (mk == m_total + 1);
      ec = 1'b0;
      if (mk >= 2 && mk <= m_ttone && !m_rest) ec = ((mk - 2) % m_div) < m_thr;
      tests++;
      if ({busy, done, clock_out} !== {eb, ed, ec}) begin
        fails++;
        model_fails++;
        $display("FAIL model_cycle t=%0t busy/done/clk got %b%b%b want %b%b%b",
                 $time, busy, done, clock_out, eb, ed, ec);
      end
    end
  endtask

  task automatic set_note(input int n, input int o, input int d, input int dy);
    note_sel = 4'(n);
    octave   = 2'(o);
    dur_ms   = 16'(d);
    cur_duty = dy;
`ifdef NOTE_DUTY_CTRL_EN
    duty_sel = 2'(dy);
`endif
  endtask

  task automatic wait_done(input string name);
    for (int c = 0; c < BUDGET && !done; c++) tick();
    check(name, int'(done), 1);
  endtask

  // Plays one note from an idle falling edge; measures the first period, the first
  // high phase, busy cycles and done pulses. stray>0 pulses start again in that cycle.
  task automatic run_note(input int n, input int o, input int d, input int dy, input int stray,
                          output int period, output int high, output int blen, output int dcnt);
    int r1, r2;
    bit prev, seen;
    r1 = -1; r2 = -1; prev = 1'b0; seen = 1'b0;
    period = 0; high = 0; blen = 0; dcnt = 0;
    set_note(n, o, d, dy);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= BUDGET && !seen; c++) begin
      if (busy) blen++;
      if (clock_out && !prev) begin
        if (r1 < 0) r1 = c;
        else if (r2 < 0) r2 = c;
      end
      if (!clock_out && prev && r1 >= 0 && high == 0) high = c - r1;
      prev = clock_out;
      if (done) begin
        dcnt++;
        seen = 1'b1;
        check("busy_low_at_done", int'(busy), 0);
      end else begin
        start = (c == stray);
        tick();
      end
    end
    start = 1'b0;
    if (!seen) check("note_timeout", 0, 1);
    if (r2 >= 0) period = r2 - r1;
    tick();
    if (done) dcnt++;
  endtask

  typedef struct {
    int n, o, d, dy;
    int period, high, blen;
  } vec_t;

  initial begin
    vec_t vt[$];
    int p, h, b, dc, n, o, d, dy, st;

    // {note, octave, dur_ms, duty, period, first high, busy cycles} at 100 kHz, gap 2 ms
    vt.push_back('{9,  0, 10, 0, 454, 227, 1200});
    vt.push_back('{9,  2, 2,  0, 113, 56,  400});
    vt.push_back('{13, 1, 3,  0, 0,   0,   500});
    vt.push_back('{0,  3, 2,  0, 95,  47,  400});
    vt.push_back('{9,  0, 0,  0, 0,   0,   201});
    vt.push_back('{11, 1, 3,  0, 202, 101, 500});
`ifdef NOTE_DUTY_CTRL_EN
    vt.push_back('{9,  0, 10, 1, 454, 113, 1200});
    vt.push_back('{9,  2, 2,  3, 113, 85,  400});
`endif

    // Reset state
    @(posedge clock_in);
    mon_en = 1'b1;
    tick();
    tick();
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_clock_out", int'(clock_out), 0);
    reset = 1'b0;
    tick();

    // Table-driven notes
    foreach (vt[i]) begin
      run_note(vt[i].n, vt[i].o, vt[i].d, vt[i].dy, 0, p, h, b, dc);
      check($sformatf("vec%0d_period", i), p, vt[i].period);
      check($sformatf("vec%0d_high", i), h, vt[i].high);
      check($sformatf("vec%0d_busy_len", i), b, vt[i].blen);
      check($sformatf("vec%0d_done_cnt", i), dc, 1);
    end

    // Reset in the middle of a tone
    set_note(9, 0, 5, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (150) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_clock_out", int'(clock_out), 0);
    check("rst_mid_done", int'(done), 0);
    dc = 0;
    repeat (700) begin
      tick();
      if (done) dc++;
    end
    check("rst_mid_no_done", dc, 0);
    run_note(9, 2, 2, 0, 0, p, h, b, dc);
    check("after_rst_busy_len", b, 400);
    check("after_rst_done_cnt", dc, 1);

    // start while busy, start in FIN, then start in the following IDLE cycle
    set_note(9, 2, 1, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (50) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_start_keeps_busy", int'(busy), 1);
    wait_done("fin_reached");
    start = 1'b1;
    tick();
    check("fin_start_ignored", int'(busy), 0);
    tick();
    start = 1'b0;
    check("idle_start_accepted", int'(busy), 1);
    wait_done("second_note_done");
    tick();

    // Randomised notes, with occasional stray starts while busy
    for (int i = 0; i < 12; i++) begin
      n  = int'($urandom_range(0, 15));
      o  = int'($urandom_range(0, 3));
      d  = int'($urandom_range(0, 3));
      dy = 0;
`ifdef NOTE_DUTY_CTRL_EN
      dy = int'($urandom_range(0, 3));
`endif
      st = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 200));
      repeat ($urandom_range(0, 3)) tick();
      run_note(n, o, d, dy, st, p, h, b, dc);
      check($sformatf("rand%0d_busy_len", i), b, ((d == 0) ? 1 : d * MS) + GAP_CYC);
      check($sformatf("rand%0d_done_cnt", i), dc, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
